// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port plus the IF/ID valid/ready output stream.
interface if_fetch_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output mem_addr, out_valid, out_instr, out_pc,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_addr, out_valid, out_instr, out_pc,
    output mem_data, out_ready
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, fetches from a combinational imem and
// queues {pc, instr} into a 2-entry buffer, with redirect, pause and range halt.
module if_fetch_ctrl #(
  parameter int          DEPTH    = 128,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  if_fetch_ctrl_if.master       bus,
  output logic                  halted,
  output logic [15:0]           fetch_cnt
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_PAUSE, S_HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  entry_t      head_q, tail_q, new_ent;
  logic [1:0]  cnt_q;
  logic        push, pop, in_range;

  assign in_range = (pc_q < DEPTH_W);
  assign new_ent  = '{pc: pc_q, instr: bus.mem_data};

  // Pop never feeds the push decision, so out_ready has no path to mem_addr.
  assign pop = (cnt_q != 2'd0) && bus.out_ready && !redirect_valid;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (redirect_valid) begin
      state_d = enable ? S_RUN : S_PAUSE;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (!enable)              state_d = S_PAUSE;
          else if (!in_range)       state_d = S_HALT;
          else if (cnt_q < 2'd2)    push    = 1'b1;
        end
        S_PAUSE: if (enable) state_d = S_RUN;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_RUN;
      endcase
    end
  end

  // Resetting into RUN behaves exactly like resetting into PAUSE when enable
  // is low: RUN with enable=0 skips the push and moves to PAUSE on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      fetch_cnt <= '0;
    end else if (redirect_valid) begin
      pc_q      <= redirect_pc;
    end else if (push) begin
      pc_q      <= pc_q + 32'd1;
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

  // Shift-style FIFO: head always holds the oldest entry so outputs come
  // straight from a register without a read-pointer mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (redirect_valid) begin
      cnt_q  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= new_ent;
          else               tail_q <= new_ent;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_q <= tail_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: head_q <= new_ent;  // push implies count was 1
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = pc_q;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_pc    = head_q.pc;
  assign bus.out_instr = head_q.instr;
  assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized + directed bench for if_fetch_ctrl against a queue-based fetch model.
module tb_if_fetch_ctrl;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;
  logic [15:0] fetch_cnt;

  if_fetch_ctrl_if bus();
  logic [31:0] mem [DEPTH];

  assign bus.mem_data = (bus.mem_addr < DEPTH) ? mem[bus.mem_addr[6:0]] : 32'h0;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .halted         (halted),
    .fetch_cnt      (fetch_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: a queue of fetched words, the next PC, and whether fetching is
  // active, paused or stopped by an out-of-range PC.
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  bit          m_run, m_halt;
  logic [15:0] m_cnt;

  function automatic void m_reset();
    m_pc = 32'd0;
    m_q.delete();
    m_run = 1'b1;
    m_halt = 1'b0;
    m_cnt = '0;
  endfunction

  function automatic void m_step();
    bit do_pop, do_push;
    do_pop  = (m_q.size() != 0) && bus.out_ready;
    do_push = 1'b0;
    if (redirect_valid) begin
      m_q.delete();
      m_pc   = redirect_pc;
      m_halt = 1'b0;
      m_run  = enable;
    end else begin
      if (!m_halt) begin
        if (!m_run)                m_run = enable;
        else if (!enable)          m_run = 1'b0;
        else if (m_pc >= DEPTH)    m_halt = 1'b1;
        else if (m_q.size() < 2)   do_push = 1'b1;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back({m_pc, mem[m_pc[6:0]]});
        m_pc  = m_pc + 32'd1;
        m_cnt = m_cnt + 16'd1;
      end
    end
  endfunction

  task automatic check_state();
    chk("valid", {31'd0, bus.out_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("out_pc", bus.out_pc, m_q[0][63:32]);
      chk("out_instr", bus.out_instr, m_q[0][31:0]);
    end
    chk("mem_addr", bus.mem_addr, m_pc);
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("fetch_cnt", {16'd0, fetch_cnt}, {16'd0, m_cnt});
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_state();
  endtask

  // Called just after a negedge: pulse reset between edges, check it is immediate.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'hA00000AA;
    for (int i = 1; i < 10; i++) mem[i] = (32'(i) << 28) | (32'(i) * 32'h11);

    bus.out_ready = 1'b1;
    enable = 1'b1;
    m_reset();

    // basic stream
    @(negedge clk);
    reset_pulse();
    repeat (10) cycle();
    chk("cnt10", {16'd0, fetch_cnt}, 32'd10);

    // backpressure from reset
    reset_pulse();
    bus.out_ready = 1'b0;
    repeat (5) cycle();
    chk("bp_addr", bus.mem_addr, 32'd2);
    chk("bp_head", bus.out_pc, 32'd0);
    bus.out_ready = 1'b1;
    repeat (6) cycle();

    // redirect with a full buffer
    bus.out_ready = 1'b0;
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'd7;
    bus.out_ready = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    chk("rd_gap", {31'd0, bus.out_valid}, 32'd0);
    cycle();
    chk("rd_pc", bus.out_pc, 32'd7);
    chk("rd_instr", bus.out_instr, 32'h70000077);
    repeat (2) cycle();

    // out-of-range halt and recovery
    redirect_valid = 1'b1;
    redirect_pc = 32'd126;
    cycle();
    redirect_valid = 1'b0;
    repeat (5) cycle();
    chk("halt", {31'd0, halted}, 32'd1);
    chk("halt_addr", bus.mem_addr, 32'd128);
    redirect_valid = 1'b1;
    redirect_pc = 32'd0;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("resume", bus.out_instr, 32'hA00000AA);
    repeat (3) cycle();

    // enable toggle
    enable = 1'b0;
    repeat (3) cycle();
    chk("drain", {31'd0, bus.out_valid}, 32'd0);
    enable = 1'b1;
    repeat (6) cycle();

    // async reset mid-stream
    reset_pulse();
    repeat (4) cycle();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      enable         = ($urandom_range(0, 9) != 0);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = 32'($urandom_range(0, DEPTH + 3));
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
